seven_segment_scanner: RTL

Time-multiplexed driver for an N-digit common-anode/common-cathode seven-segment display. Captures a packed BCD/hex word, transfers it tear-free at frame boundaries, and scans one digit at a time at a programmable rate. Supports hex or decimal decoding, leading-zero suppression, per-digit decimal points, blanking and selectable output polarity. Sits between counter/datapath logic and the board display pins, superseding the single-digit combinational decoder.

---
 rtl/seven_segment_pkg.sv | 25 ++
 rtl/seg7_decode.sv | 37 +++
 rtl/seven_segment_scanner.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/seven_segment_pkg.sv
// Segment encodings shared by the scanner and its decoder.
// Patterns are active-high, bit0 = a ... bit6 = g.
package seven_segment_pkg;

    localparam logic [6:0] SEG_0 = 7'b0111111;
    localparam logic [6:0] SEG_1 = 7'b0000110;
    localparam logic [6:0] SEG_2 = 7'b1011011;
    localparam logic [6:0] SEG_3 = 7'b1001111;
    localparam logic [6:0] SEG_4 = 7'b1100110;
    localparam logic [6:0] SEG_5 = 7'b1101101;
    localparam logic [6:0] SEG_6 = 7'b1111101;
    localparam logic [6:0] SEG_7 = 7'b0000111;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1101111;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b1111100;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_D = 7'b1011110;
    localparam logic [6:0] SEG_E = 7'b1111001;
    localparam logic [6:0] SEG_F = 7'b1110001;

    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble decoder; in decimal mode values above 9 render as a dash.
module seg7_decode
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        if (!hex_mode && (nibble > 4'd9)) begin
            pattern = SEG_DASH;
        end else begin
            case (nibble)
                4'h0: pattern = SEG_0;
                4'h1: pattern = SEG_1;
                4'h2: pattern = SEG_2;
                4'h3: pattern = SEG_3;
                4'h4: pattern = SEG_4;
                4'h5: pattern = SEG_5;
                4'h6: pattern = SEG_6;
                4'h7: pattern = SEG_7;
                4'h8: pattern = SEG_8;
                4'h9: pattern = SEG_9;
                4'hA: pattern = SEG_A;
                4'hB: pattern = SEG_B;
                4'hC: pattern = SEG_C;
                4'hD: pattern = SEG_D;
                4'hE: pattern = SEG_E;
                4'hF: pattern = SEG_F;
                default: pattern = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronised
// display updates, leading-zero suppression, blanking and pin polarity select.
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    hex_mode,
    input  logic                    lz_suppress,
    input  logic                    blank,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [PRE_W-1:0]        presc;
    logic [IDX_W-1:0]        idx;
    logic                    tick;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] stage_digits;
    logic [NUM_DIGITS-1:0]   stage_dp;
    logic                    pending;
    logic [4*NUM_DIGITS-1:0] disp_digits;
    logic [NUM_DIGITS-1:0]   disp_dp;

    logic [NUM_DIGITS-1:0]   suppress;
    logic                    zero_above;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_sup;
    logic [NUM_DIGITS-1:0]   sel;
    logic [6:0]              dec_pat;

    logic [6:0]              seg_nxt;
    logic                    dp_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;

    assign tick = (presc == PRE_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A load landing on the wrap cycle bypasses staging so it shows in the very next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_digits <= '0;
            stage_dp     <= '0;
            pending      <= 1'b0;
            disp_digits  <= '0;
            disp_dp      <= '0;
        end else begin
            if (load) begin
                stage_digits <= digits;
                stage_dp     <= dp_in;
            end
            if (wrap) begin
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
            if (wrap && load) begin
                disp_digits <= digits;
                disp_dp     <= dp_in;
            end else if (wrap && pending) begin
                disp_digits <= stage_digits;
                disp_dp     <= stage_dp;
            end
        end
    end

    // Walk from the most significant digit down; a digit is suppressed while
    // it and everything above it are zero. Digit 0 is never suppressed.
    always_comb begin
        suppress   = '0;
        zero_above = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above  = zero_above && (disp_digits[4*i +: 4] == 4'd0);
            suppress[i] = zero_above && lz_suppress;
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        cur_sup = 1'b0;
        sel     = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib = disp_digits[4*i +: 4];
                cur_dp  = disp_dp[i];
                cur_sup = suppress[i];
                sel[i]  = 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .nibble   (cur_nib),
        .hex_mode (hex_mode),
        .pattern  (dec_pat)
    );

    always_comb begin
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b0;
        an_nxt  = '0;
        if (!blank) begin
            seg_nxt = cur_sup ? SEG_OFF : dec_pat;
            dp_nxt  = cur_dp;
            an_nxt  = sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segments   <= {7{POL}};
            dp         <= POL;
            anodes     <= {NUM_DIGITS{POL}};
            frame_done <= 1'b0;
        end else begin
            segments   <= seg_nxt ^ {7{POL}};
            dp         <= dp_nxt ^ POL;
            anodes     <= an_nxt ^ {NUM_DIGITS{POL}};
            frame_done <= wrap;
        end
    end

endmodule
